// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA 640x480 timing, derived totals/offsets and capture FSM encoding
package vga_pkg;
  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_TOTAL  = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int unsigned H_START  = H_SYNC + H_BP;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;
  localparam int unsigned V_FP     = 10;
  localparam int unsigned V_TOTAL  = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int unsigned V_START  = V_SYNC + V_BP;
  localparam int CNT_W = 12;
  typedef logic [CNT_W-1:0] cnt_t;
  typedef struct packed {
    int unsigned h_active;
    int unsigned h_sync;
    int unsigned h_bp;
    int unsigned h_fp;
    int unsigned v_active;
    int unsigned v_sync;
    int unsigned v_bp;
    int unsigned v_fp;
  } vga_timing_t;
  localparam vga_timing_t VGA_640X480 = '{
    h_active: H_ACTIVE, h_sync: H_SYNC, h_bp: H_BP, h_fp: H_FP,
    v_active: V_ACTIVE, v_sync: V_SYNC, v_bp: V_BP, v_fp: V_FP
  };
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TRAIN  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;
  function automatic int unsigned h_total(input vga_timing_t t);
    return t.h_sync + t.h_bp + t.h_active + t.h_fp;
  endfunction
  function automatic int unsigned v_total(input vga_timing_t t);
    return t.v_sync + t.v_bp + t.v_active + t.v_fp;
  endfunction
  function automatic int unsigned h_start(input vga_timing_t t);
    return t.h_sync + t.h_bp;
  endfunction
  function automatic int unsigned v_start(input vga_timing_t t);
    return t.v_sync + t.v_bp;
  endfunction
endpackage

// File: rtl/vga_sync_edge.sv
// vga_sync_edge: remembers an active-low sync level across strobes and flags its falling edge
module vga_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic smp,
  input  logic s_in,
  output logic fall
);
  logic prev_q, prev_d;
  always_comb begin
    prev_d = smp ? s_in : prev_q;
  end
  always_ff @(posedge clk) begin
    if (rst) prev_q <= 1'b1;
    else prev_q <= prev_d;
  end
  assign fall = smp && prev_q && !s_in;
endmodule

// File: rtl/vga_capture.sv
// vga_capture: locks onto VGA HS/VS timing and emits registered active pixels with row/col
module vga_capture
  import vga_pkg::*;
#(
  parameter vga_timing_t T = VGA_640X480
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_en,
  input  logic        HS,
  input  logic        VS,
  input  logic [3:0]  R,
  input  logic [3:0]  G,
  input  logic [3:0]  B,
  output logic        pix_valid,
  output logic [11:0] pix_data,
  output logic [8:0]  row,
  output logic [9:0]  col,
  output logic        frame_start,
  output logic        frame_done,
  output logic        locked,
  output logic        sync_err
);
  localparam cnt_t H_LAST = cnt_t'(h_total(T) - 1);
  localparam cnt_t H_OVR  = cnt_t'(h_total(T));
  localparam cnt_t V_LAST = cnt_t'(v_total(T) - 1);
  localparam cnt_t V_OVR  = cnt_t'(v_total(T));
  localparam cnt_t X0 = cnt_t'(h_start(T));
  localparam cnt_t X1 = cnt_t'(h_start(T) + T.h_active - 1);
  localparam cnt_t Y0 = cnt_t'(v_start(T));
  localparam cnt_t Y1 = cnt_t'(v_start(T) + T.v_active - 1);
  state_t      state_q, state_d;
  cnt_t        hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic        pix_valid_q, pix_valid_d;
  logic [11:0] pix_data_q, pix_data_d;
  logic [8:0]  row_q, row_d;
  logic [9:0]  col_q, col_d;
  logic        frame_start_q, frame_start_d;
  logic        frame_done_q, frame_done_d;
  logic        sync_err_q, sync_err_d;
  logic        hs_fall, vs_fall, line_err, frame_err, err, act;
  vga_sync_edge u_hs (.clk(clk), .rst(rst), .smp(pix_en),  .s_in(HS), .fall(hs_fall));
  // VS history is only updated at HS falls, so a VS fall is a line-level event
  vga_sync_edge u_vs (.clk(clk), .rst(rst), .smp(hs_fall), .s_in(VS), .fall(vs_fall));
  always_comb begin
    line_err = hs_fall ? hcnt_q != H_LAST : pix_en && hcnt_q == H_LAST;
    frame_err = hs_fall && (vs_fall ? vcnt_q != V_LAST : vcnt_q == V_LAST);
    err = line_err || frame_err;
    // counters park at their overrun value so an overrun is reported once, never wrapped
    hcnt_d = !pix_en ? hcnt_q : hs_fall ? '0 : hcnt_q == H_OVR ? hcnt_q : hcnt_q + 1'b1;
    vcnt_d = !hs_fall ? vcnt_q : vs_fall ? '0 : vcnt_q == V_OVR ? vcnt_q : vcnt_q + 1'b1;
    state_d = state_q == ST_IDLE ? (vs_fall ? ST_TRAIN : ST_IDLE) :
              err ? ST_IDLE : vs_fall ? ST_LOCKED : state_q;
    act = pix_en && state_q == ST_LOCKED && hcnt_d >= X0 && hcnt_d <= X1 &&
          vcnt_d >= Y0 && vcnt_d <= Y1;
    pix_valid_d = act;
    pix_data_d = act ? {R, G, B} : pix_data_q;
    col_d = act ? 10'(hcnt_d - X0) : col_q;
    row_d = act ? 9'(vcnt_d - Y0) : row_q;
    frame_start_d = act && hcnt_d == X0 && vcnt_d == Y0;
    frame_done_d = act && hcnt_d == X1 && vcnt_d == Y1;
    sync_err_d = err && state_q != ST_IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      pix_valid_q   <= 1'b0;
      pix_data_q    <= '0;
      row_q         <= '0;
      col_q         <= '0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      pix_valid_q   <= pix_valid_d;
      pix_data_q    <= pix_data_d;
      row_q         <= row_d;
      col_q         <= col_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
      sync_err_q    <= sync_err_d;
    end
  end
  assign pix_valid   = pix_valid_q;
  assign pix_data    = pix_data_q;
  assign row         = row_q;
  assign col         = col_q;
  assign frame_start = frame_start_q;
  assign frame_done  = frame_done_q;
  assign sync_err    = sync_err_q;
  assign locked      = state_q == ST_LOCKED;
endmodule

// File: tb/tb_vga_capture.sv
// tb_vga_capture: reduced-geometry VGA source with a sample-position reference model
module tb_vga_capture;
  import vga_pkg::*;
  localparam int HA = 8, HSY = 2, HBP = 3, HFP = 2;
  localparam int VA = 4, VSY = 1, VBP = 2, VFP = 1;
  localparam int HT = HA + HSY + HBP + HFP;
  localparam int VT = VA + VSY + VBP + VFP;
  localparam int X0 = HSY + HBP;
  localparam int Y0 = VSY + VBP;
  localparam int M_IDLE = 0, M_TRAIN = 1, M_LOCKED = 2;
  localparam vga_timing_t TB_T = '{
    h_active: 32'(HA), h_sync: 32'(HSY), h_bp: 32'(HBP), h_fp: 32'(HFP),
    v_active: 32'(VA), v_sync: 32'(VSY), v_bp: 32'(VBP), v_fp: 32'(VFP)
  };
  logic clk = 1'b0;
  logic rst, pix_en, HS, VS;
  logic [3:0] R, G, B;
  logic pix_valid, frame_start, frame_done, locked, sync_err;
  logic [11:0] pix_data;
  logic [8:0] row;
  logic [9:0] col;
  vga_capture #(.T(TB_T)) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en), .HS(HS), .VS(VS), .R(R), .G(G), .B(B),
    .pix_valid(pix_valid), .pix_data(pix_data), .row(row), .col(col),
    .frame_start(frame_start), .frame_done(frame_done), .locked(locked), .sync_err(sync_err)
  );
  always #5 clk = ~clk;
  int m_state = M_IDLE, pos = 0, ln = 0;
  bit p_hs = 1'b1, p_vs = 1'b1;
  logic o_pv = 0, o_fs = 0, o_fd = 0, o_se = 0, o_lk = 0;
  logic [11:0] o_data = '0;
  logic [8:0] o_row = '0;
  logic [9:0] o_col = '0;
  logic e_pv = 0, e_fs = 0, e_fd = 0, e_se = 0, e_lk = 0;
  logic [11:0] e_data = '0;
  logic [8:0] e_row = '0;
  logic [9:0] e_col = '0;
  int errors = 0, checks = 0, pv_total = 0, fd_total = 0, se_total = 0, gap = 0, n0;
  bit chk_on = 0, got_first = 0;
  logic [11:0] first_data = '0;
  logic [8:0] first_row = '1;
  logic [9:0] first_col = '1;
  logic first_fs = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // Expected outputs after the coming edge, from line/frame position rules
  task automatic model_step(input bit r, input bit pe, input bit hs, input bit vs,
                            input logic [11:0] c);
    bit hf, vf, bad;
    int x, y;
    if (r) begin
      m_state = M_IDLE; pos = 0; ln = 0; p_hs = 1; p_vs = 1;
      o_pv = 0; o_fs = 0; o_fd = 0; o_se = 0; o_lk = 0;
      o_data = '0; o_row = '0; o_col = '0;
    end else begin
      o_pv = 0; o_fs = 0; o_fd = 0; o_se = 0;
      if (pe) begin
        hf = p_hs && !hs;
        p_hs = hs;
        vf = 0;
        bad = 0;
        if (hf) begin
          bad = pos != HT - 1;
          vf = p_vs && !vs;
          p_vs = vs;
          bad = bad || (vf ? ln != VT - 1 : ln + 1 == VT);
          ln = vf ? 0 : ln + 1;
          pos = 0;
        end else begin
          pos++;
          bad = pos == HT;
        end
        x = pos - X0;
        y = ln - Y0;
        if (m_state == M_LOCKED && x >= 0 && x < HA && y >= 0 && y < VA) begin
          o_pv = 1; o_data = c; o_col = 10'(x); o_row = 9'(y);
          o_fs = x == 0 && y == 0;
          o_fd = x == HA - 1 && y == VA - 1;
        end
        if (m_state != M_IDLE && bad) begin
          o_se = 1;
          m_state = M_IDLE;
        end else if (vf) m_state = m_state == M_IDLE ? M_TRAIN : M_LOCKED;
      end
      o_lk = m_state == M_LOCKED;
    end
  endtask
  task automatic tick(input bit r, input bit pe, input bit hs, input bit vs, input logic [11:0] c);
    @(posedge clk);
    #1;
    rst = r; pix_en = pe; HS = hs; VS = vs; {R, G, B} = c;
    model_step(r, pe, hs, vs, c);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 1'($urandom), 1'($urandom), 12'($urandom));
  endtask
  function automatic logic [11:0] pat(input int h, input int v);
    return (h == X0 && v == Y0) ? 12'hF0A : {4'(h), 4'(v), 4'(3 * h + v)};
  endfunction
  task automatic line(input int len, input bit vsl, input int v, input int rst_at, input int pause_at);
    for (int h = 0; h < len; h++) begin
      if (h == pause_at) idle(1000);
      tick(h == rst_at, 1, h >= HSY, !vsl, pat(h, v));
      if (h == rst_at) begin
        idle(1);
        chk("rst_valid", pix_valid, 0);
        chk("rst_data", pix_data, 0);
        chk("rst_row", row, 0);
        chk("rst_col", col, 0);
        chk("rst_locked", locked, 0);
      end
      idle(gap);
    end
  endtask
  task automatic frame(input int short_line, input bit no_vs, input int rst_line, input int pause_line);
    for (int v = 0; v < VT; v++)
      line(v == short_line ? HT - 1 : HT, !no_vs && v < VSY, v,
           v == rst_line ? 7 : -1, v == pause_line ? 8 : -1);
  endtask
  always @(posedge clk) begin
    e_pv <= o_pv; e_fs <= o_fs; e_fd <= o_fd; e_se <= o_se; e_lk <= o_lk;
    e_data <= o_data; e_row <= o_row; e_col <= o_col;
  end
  always @(negedge clk) begin
    if (chk_on) begin
      chk("pix_valid", pix_valid, e_pv);
      chk("pix_data", pix_data, e_data);
      chk("row", row, e_row);
      chk("col", col, e_col);
      chk("frame_start", frame_start, e_fs);
      chk("frame_done", frame_done, e_fd);
      chk("sync_err", sync_err, e_se);
      chk("locked", locked, e_lk);
      if (pix_valid === 1'b1) pv_total++;
      if (frame_done === 1'b1) fd_total++;
      if (sync_err === 1'b1) se_total++;
      if (pix_valid === 1'b1 && !got_first) begin
        got_first = 1;
        first_data = pix_data; first_row = row; first_col = col; first_fs = frame_start;
      end
    end
  end
  initial begin
    rst = 1; pix_en = 0; HS = 1; VS = 1; {R, G, B} = '0;
    tick(1, 0, 1, 1, 12'h000);
    tick(1, 1, 0, 0, 12'hFFF);
    tick(1, 0, 1, 1, 12'h000);
    chk_on = 1;
    idle(2);
    chk("reset_locked", locked, 0);
    chk("reset_valid", pix_valid, 0);
    chk("reset_data", pix_data, 0);
    gap = 3;
    frame(-1, 0, -1, -1); idle(2);
    chk("f1_pixels", pv_total, 0);
    chk("f1_locked", locked, 0);
    frame(-1, 0, -1, -1); idle(2);
    chk("f2_pixels", pv_total, VA * HA);
    chk("f2_locked", locked, 1);
    chk("first_data", first_data, 12'hF0A);
    chk("first_row", first_row, 0);
    chk("first_col", first_col, 0);
    chk("first_fs", first_fs, 1);
    frame(-1, 0, -1, -1); idle(2);
    chk("clean_serr", se_total, 0);
    chk("clean_done", fd_total, 2);
    gap = 0;
    frame(4, 0, -1, -1); idle(2);
    chk("short_serr", se_total, 1);
    chk("short_locked", locked, 0);
    frame(-1, 0, -1, -1); idle(2);
    chk("relock_train", locked, 0);
    frame(-1, 0, -1, -1); idle(2);
    chk("relock_done", locked, 1);
    frame(-1, 1, -1, -1); idle(2);
    chk("novs_serr", se_total, 2);
    chk("novs_locked", locked, 0);
    frame(-1, 0, -1, -1); idle(2);
    chk("novs_train", locked, 0);
    frame(-1, 0, -1, -1); idle(2);
    chk("novs_relock", locked, 1);
    frame(-1, 0, Y0 + 2, -1); idle(2);
    chk("rst_no_done", fd_total, 4);
    chk("rst_unlocked", locked, 0);
    frame(-1, 0, -1, -1); idle(2);
    chk("rst_train", locked, 0);
    frame(-1, 0, -1, -1); idle(2);
    chk("rst_relock", locked, 1);
    n0 = pv_total;
    frame(-1, 0, -1, Y0 + 1); idle(2);
    chk("pause_pixels", pv_total - n0, VA * HA);
    chk("pause_serr", se_total, 2);
    chk("final_done", fd_total, 6);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vga_capture.md
VGA_CAPTURE -- requirements
Module: vga_capture

Interface
REQ-001 H_ACTIVE, 640, active pixels per line.
REQ-002 H_SYNC / H_BP / H_FP, 96 / 48 / 16, horizontal sync, back-porch and front-porch pixels; H_TOTAL = 800.
REQ-003 V_ACTIVE, 480, active lines per frame.
REQ-004 V_SYNC / V_BP / V_FP, 2 / 33 / 10, vertical sync, back-porch and front-porch lines; V_TOTAL = 525.
REQ-005 clk  in  1  single clock; one clock, all logic on its rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 pix_en  in  1  pixel strobe; inputs are sampled only in clk cycles where pix_en=1.
REQ-008 HS, VS  in  1 each  sync inputs, active-low.
REQ-009 R, G, B  in  4 each  colour inputs.
REQ-010 pix_valid  out  1  captured active pixel present this cycle.
REQ-011 pix_data  out  12  {R,G,B} of the captured pixel.
REQ-012 row  out  9  active row 0..479; col  out  10  active column 0..639.
REQ-013 frame_start, frame_done  out  1 each  single-cycle frame markers.
REQ-014 locked  out  1  timing lock; sync_err  out  1  single-cycle timing-violation pulse.

Function
REQ-015 Sample cycle: clk edge with pix_en=1; no state changes on non-sample cycles, and pix_valid, frame_start, frame_done and sync_err are 0 on non-sample cycles.
REQ-016 HS fall: a sample with HS=0 where the previous sample had HS=1; at that sample hcnt := 0, otherwise hcnt increments by 1 per sample.
REQ-017 At each HS fall: vcnt := 0 if VS=0 and VS was 1 at the previous HS fall, else vcnt := vcnt+1.
REQ-018 Active region: hcnt in 144..783 and vcnt in 35..514; col = hcnt-144 and row = vcnt-35, computed at full width and then truncated.
REQ-019 FSM states: IDLE, TRAIN, LOCKED.
REQ-020 IDLE->TRAIN on the first VS-fall line (vcnt set to 0).
REQ-021 TRAIN->LOCKED on the next VS-fall line, if vcnt was 524 and no line error occurred.
REQ-022 Line error: an HS fall with previous hcnt != 799, or hcnt reaching 800 without an HS fall.
REQ-023 Frame error: a VS-fall line with previous vcnt != 524, or vcnt reaching 525 without a VS fall.
REQ-024 Any line or frame error in TRAIN or LOCKED: sync_err=1 for one cycle, next state IDLE, locked=0 the following cycle; errors are ignored in IDLE.
REQ-025 An error and a VS fall in the same sample: the error wins and the state is IDLE; the next VS fall restarts TRAIN.
REQ-026 locked=1 exactly while state is LOCKED.
REQ-027 Latency: outputs are registered, and an active sample at edge N appears as pix_valid=1 with pix_data/row/col on the cycle after edge N (1 clk).
REQ-028 pix_valid=1 only in LOCKED; pix_data, row and col hold their last values when pix_valid=0.
REQ-029 frame_start=1 together with the pix_valid of (row 0, col 0); frame_done=1 together with the pix_valid of (row 479, col 639).
REQ-030 Counter wrap: hcnt and vcnt never wrap silently; overrun is reported as an error per REQ-022/REQ-023.

Reset
REQ-031 While rst=1 at a clk edge: state IDLE, hcnt=vcnt=0, stored HS/VS history=1, and all outputs 0 on the next cycle.
REQ-032 Reset mid-frame discards the partial frame: no frame_done is issued, and re-lock requires one full TRAIN frame.
REQ-033 rst overrides pix_en.

Structure
REQ-034 Timing constants, derived totals/offsets and the FSM state encoding shall live in shared package vga_pkg.
REQ-035 HS/VS sampling and fall detection shall be one sub-module, vga_sync_edge, instantiated twice.

Verification
REQ-036 Clean 640x480 source with pix_en every 4th clk, 3 frames -> sync_err never asserted; locked=1 from the start of frame 2; 307200 pix_valid pulses in frame 2 only; first pixel row=0, col=0.
REQ-037 Pixel at hcnt=144, vcnt=35 with RGB=F/0/A -> one clk after that sample: pix_valid=1, pix_data=12'hF0A, row=0, col=0, frame_start=1.
REQ-038 While locked, one line shortened to 799 samples -> sync_err pulse at that HS fall; locked=0 next cycle; re-lock after 2 further VS falls.
REQ-039 While locked, VS fall withheld -> sync_err when vcnt would reach 525; state IDLE.
REQ-040 rst asserted for 1 clk at row 200 -> all outputs 0 next cycle; no frame_done for that frame; locked returns after the next full frame.
REQ-041 pix_en held low for 1000 clk mid-line -> no output changes and no errors; capture resumes seamlessly.
